dsi_line_scheduler: RTL and testbench
=====================================

Name: dsi_line_scheduler

Overview:
- Sequences the DSI video-mode packet stream for one display.
- Runs the frame line counter and a per-line cycle timer.
- Issues one packet request at a time (VSS/HSS/HBP/RGB/HFP/BLANK/CMD) to the packets assembler over a req/done handshake.
- Decides per line whether the lanes go to LPM or are filled with a blank packet, and grants queued-command slots only where the remaining line time allows.

Parameters:
- LINE_W, 16, width of the line-period cycle timer and cmd_min_cycles.
- VCNT_W, 12, width of the vertical line counts and the line counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- stream_enable  in  1  level; start/keep streaming frames
- lpm_enable  in  1  1: non-active lines go to LPM after sync; 0: send BLANK
- line_period  in  LINE_W  clk cycles per line, minus 1 (must be ≥ 3)
- vsa_lines  in  VCNT_W  sync-active lines (≥ 1)
- vbp_lines  in  VCNT_W  back-porch lines
- vact_lines  in  VCNT_W  active lines (≥ 1)
- vfp_lines  in  VCNT_W  front-porch lines
- cmd_pending  in  1  command FIFO not empty
- cmd_min_cycles  in  LINE_W  minimum remaining line cycles needed to grant a CMD
- pkt_req  out  1  packet request; held until pkt_done
- pkt_type  out  3  0 VSS, 1 HSS, 2 HBP, 3 RGB, 4 HFP, 5 BLANK, 6 CMD; stable while pkt_req=1
- pkt_done  in  1  one-cycle pulse: assembler finished the requested packet
- lpm_rqst  out  1  lanes may enter LPM (high in the LPM state only)
- frame_start  out  1  one-cycle pulse at the start of line 0
- line_start  out  1  one-cycle pulse at the start of every line
- line_overrun  out  1  sticky; set when a line boundary arrives while not in WAIT_LINE/LPM; cleared only by stream_enable 0→1 or reset

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters 0.
- Line timer: loads line_period at every line start, then decrements each cycle and saturates at 0. line_end = (timer==0).
- Line counter: 0..total-1, where total = vsa+vbp+vact+vfp, evaluated at VCNT_W+2 bits.
  - Region decode from the counter: sync < vsa; active in [vsa+vbp, vsa+vbp+vact).
- FSM states: IDLE, SYNC, HBP, RGB, HFP, FILL, CMD, WAIT_LINE, LPM.
- IDLE:
  - stream_enable=1 → line counter=0, pulse frame_start and line_start, enter SYNC.
  - A rising edge of stream_enable clears line_overrun.
- SYNC: pkt_req=1; pkt_type = VSS on line 0, HSS otherwise. On pkt_done:
  - Active line → HBP.
  - Other line, lpm_enable=1 → LPM.
  - Other line, lpm_enable=0 → FILL.
- HBP → RGB → HFP: each holds pkt_req until pkt_done, then advances. After HFP done → CMD-check.
- FILL: BLANK request. On done → CMD-check.
- CMD-check (combinational on the transition):
  - cmd_pending=1 and timer ≥ cmd_min_cycles → CMD.
  - Otherwise → WAIT_LINE (lpm_enable=0) or LPM (lpm_enable=1).
- CMD: request type 6. On done → re-run CMD-check, so multiple commands fit in one line.
- WAIT_LINE / LPM:
  - On line_end: increment the line counter (wrap to 0 at total-1) and pulse line_start (plus frame_start when wrapping).
  - Then go to SYNC, or to IDLE if the counter wrapped and stream_enable=0.
- Frame stop: stream_enable falling mid-frame takes effect only at the frame boundary; the frame always completes.
- pkt_req deasserts the cycle after pkt_done; the next request asserts no earlier than one cycle later.
  - pkt_done while pkt_req=0 is ignored.
- Overrun:
  - If line_end occurs in any request state, set line_overrun and latch a pending-line flag.
  - The current packet still finishes. The next line starts immediately after its pkt_done (CMD-check skipped) and the timer reloads then.
- pkt_type and pkt_req are registered outputs (no combinational path from pkt_done).
- Reset mid-packet: pkt_req drops asynchronously; the assembler is reset from the same rst_n.

Decomposition:
- Shared package dsi_pkg:
  - pkt_type enum (VSS..CMD, 3 bits).
  - FSM state enum.
  - DSI data-type constants (0x01 VSS, 0x21 HSS, 0x19 blank, 0x3E RGB888) for later use by the assembler.
- One sub-module: dsi_vtiming_counter (line timer + line counter + region decode + line_start/frame_start). The FSM stays in the top.

Test Plan:
- vsa=1, vbp=1, vact=2, vfp=1, line_period=39, lpm_enable=0, no cmds, done 3 cycles after req → per frame: VSS,BLANK | HSS,BLANK | HSS,HBP,RGB,HFP ×2 | HSS,BLANK. line_start every 40 cycles; frame_start every 200.
- Same config, lpm_enable=1 → non-active lines issue only the sync packet. lpm_rqst high from sync done until line_end; never asserted on active lines.
- cmd_pending=1 held, cmd_min_cycles=10, done latency 3 → CMD packets repeat in each line until timer < 10. Zero CMD requests when cmd_min_cycles > line_period.
- RGB done delayed 60 cycles (line_period=39) → line_overrun=1. HSS issued the cycle after RGB's done+1, skipping HFP-check delays; overrun stays set until stream_enable toggles.
- stream_enable dropped on line 2 → frame finishes through line 4, then IDLE with pkt_req=0. Re-enable → frame_start and VSS.
- rst_n asserted while pkt_req=1 in RGB → all outputs 0 immediately. After release, IDLE until stream_enable.

Source files
------------

// File: rtl/dsi_pkg.sv
// dsi_pkg: shared packet types, scheduler states and DSI data-type codes
package dsi_pkg;
  typedef enum logic [2:0] {
    PKT_VSS   = 3'd0,
    PKT_HSS   = 3'd1,
    PKT_HBP   = 3'd2,
    PKT_RGB   = 3'd3,
    PKT_HFP   = 3'd4,
    PKT_BLANK = 3'd5,
    PKT_CMD   = 3'd6
  } pkt_type_e;
  typedef logic [3:0] state_t;
  localparam state_t ST_IDLE = 4'd0;
  localparam state_t ST_SYNC = 4'd1;
  localparam state_t ST_HBP  = 4'd2;
  localparam state_t ST_RGB  = 4'd3;
  localparam state_t ST_HFP  = 4'd4;
  localparam state_t ST_FILL = 4'd5;
  localparam state_t ST_CMD  = 4'd6;
  localparam state_t ST_WAIT = 4'd7;
  localparam state_t ST_LPM  = 4'd8;
  localparam logic [7:0] DT_VSS    = 8'h01;
  localparam logic [7:0] DT_HSS    = 8'h21;
  localparam logic [7:0] DT_BLANK  = 8'h19;
  localparam logic [7:0] DT_RGB888 = 8'h3E;
endpackage

// File: rtl/dsi_vtiming_counter.sv
// dsi_vtiming_counter: per-line cycle timer, frame line counter and region decode
module dsi_vtiming_counter #(
  parameter int LINE_W = 16,
  parameter int VCNT_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              advance,
  input  logic [LINE_W-1:0] line_period,
  input  logic [VCNT_W-1:0] vsa_lines,
  input  logic [VCNT_W-1:0] vbp_lines,
  input  logic [VCNT_W-1:0] vact_lines,
  input  logic [VCNT_W-1:0] vfp_lines,
  output logic [LINE_W-1:0] timer,
  output logic [VCNT_W-1:0] line_cnt,
  output logic              line_end,
  output logic              last_line,
  output logic              active,
  output logic              line_start,
  output logic              frame_start
);
  localparam int CW = VCNT_W + 2;
  logic [LINE_W-1:0] timer_q, timer_d;
  logic [VCNT_W-1:0] cnt_q, cnt_d;
  logic              ls_q, ls_d, fs_q, fs_d;
  logic [CW-1:0]     act_lo, act_hi, total, cnt_x;
  assign act_lo    = CW'(vsa_lines) + CW'(vbp_lines);
  assign act_hi    = act_lo + CW'(vact_lines);
  assign total     = act_hi + CW'(vfp_lines);
  assign cnt_x     = CW'(cnt_q);
  assign last_line = cnt_x == total - CW'(1);
  assign active    = cnt_x >= act_lo && cnt_x < act_hi;
  assign line_end  = timer_q == '0;
  assign timer     = timer_q;
  assign line_cnt  = cnt_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  // reload the timer on every new line, otherwise count down to zero and hold
  always_comb begin
    timer_d = (start || advance) ? line_period : (line_end ? timer_q : timer_q - LINE_W'(1));
    cnt_d   = start ? '0 : advance ? (last_line ? '0 : cnt_q + VCNT_W'(1)) : cnt_q;
    ls_d    = start || advance;
    fs_d    = start || (advance && last_line);
  end
  // timing state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      cnt_q   <= '0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end
endmodule

// File: rtl/dsi_line_scheduler.sv
// dsi_line_scheduler: sequences DSI video-mode packets, LPM/blank fill and command slots per line
module dsi_line_scheduler
  import dsi_pkg::*;
#(
  parameter int LINE_W = 16,
  parameter int VCNT_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stream_enable,
  input  logic              lpm_enable,
  input  logic [LINE_W-1:0] line_period,
  input  logic [VCNT_W-1:0] vsa_lines,
  input  logic [VCNT_W-1:0] vbp_lines,
  input  logic [VCNT_W-1:0] vact_lines,
  input  logic [VCNT_W-1:0] vfp_lines,
  input  logic              cmd_pending,
  input  logic [LINE_W-1:0] cmd_min_cycles,
  output logic              pkt_req,
  output logic [2:0]        pkt_type,
  input  logic              pkt_done,
  output logic              lpm_rqst,
  output logic              frame_start,
  output logic              line_start,
  output logic              line_overrun
);
  state_t            state_q, state_d, succ, chk_state;
  pkt_type_e         type_q, type_d, req_type;
  logic              req_q, req_d, ovr_q, ovr_d, pend_q, pend_d, en_q;
  logic              start, advance, boundary, stop, in_req, wait_st;
  logic [LINE_W-1:0] timer;
  logic [VCNT_W-1:0] line_cnt;
  logic              line_end, last_line, active;
  dsi_vtiming_counter #(.LINE_W(LINE_W), .VCNT_W(VCNT_W)) u_vt (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .advance    (advance),
    .line_period(line_period),
    .vsa_lines  (vsa_lines),
    .vbp_lines  (vbp_lines),
    .vact_lines (vact_lines),
    .vfp_lines  (vfp_lines),
    .timer      (timer),
    .line_cnt   (line_cnt),
    .line_end   (line_end),
    .last_line  (last_line),
    .active     (active),
    .line_start (line_start),
    .frame_start(frame_start)
  );
  assign wait_st   = state_q == ST_WAIT || state_q == ST_LPM;
  assign in_req    = state_q != ST_IDLE && !wait_st;
  assign chk_state = (cmd_pending && timer >= cmd_min_cycles) ? ST_CMD :
                     (lpm_enable && !active) ? ST_LPM : ST_WAIT;
  assign succ      = state_q == ST_SYNC ? (active ? ST_HBP : lpm_enable ? ST_LPM : ST_FILL) :
                     state_q == ST_HBP ? ST_RGB : state_q == ST_RGB ? ST_HFP : chk_state;
  assign req_type  = state_q == ST_SYNC ? (line_cnt == '0 ? PKT_VSS : PKT_HSS) :
                     state_q == ST_HBP ? PKT_HBP : state_q == ST_RGB ? PKT_RGB :
                     state_q == ST_HFP ? PKT_HFP : state_q == ST_FILL ? PKT_BLANK : PKT_CMD;
  assign boundary  = wait_st ? line_end : (in_req && req_q && pkt_done && (pend_q || line_end));
  assign stop      = last_line && !stream_enable;
  assign start     = state_q == ST_IDLE && stream_enable;
  assign advance   = boundary && !stop;
  assign pkt_req      = req_q;
  assign pkt_type     = type_q;
  assign lpm_rqst     = state_q == ST_LPM;
  assign line_overrun = ovr_q;
  // packet handshake, overrun tracking and line-boundary sequencing
  always_comb begin
    state_d = start ? ST_SYNC : state_q;
    req_d   = req_q;
    type_d  = type_q;
    pend_d  = pend_q;
    ovr_d   = ovr_q && !(stream_enable && !en_q);
    if (in_req && line_end) begin
      ovr_d  = 1'b1;
      pend_d = 1'b1;
    end
    if (in_req && !req_q) begin
      req_d  = 1'b1;
      type_d = req_type;
    end
    if (in_req && req_q && pkt_done) begin
      req_d   = 1'b0;
      state_d = succ;
    end
    if (boundary) begin
      state_d = stop ? ST_IDLE : ST_SYNC;
      pend_d  = 1'b0;
    end
  end
  // scheduler registers; reset drops the request immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      type_q  <= PKT_VSS;
      ovr_q   <= 1'b0;
      pend_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      type_q  <= type_d;
      ovr_q   <= ovr_d;
      pend_q  <= pend_d;
      en_q    <= stream_enable;
    end
  end
endmodule

// File: tb/tb_dsi_line_scheduler.sv
// tb_dsi_line_scheduler: directed checks of packet order, line timing, LPM, commands, overrun and reset
module tb_dsi_line_scheduler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stream_enable = 1'b0;
  logic        lpm_enable = 1'b0;
  logic        cmd_pending = 1'b0;
  logic        pkt_done = 1'b0;
  logic [15:0] line_period = 16'd39;
  logic [15:0] cmd_min_cycles = 16'd10;
  logic [11:0] vsa_lines = 12'd1, vbp_lines = 12'd1, vact_lines = 12'd2, vfp_lines = 12'd1;
  logic        pkt_req, lpm_rqst, frame_start, line_start, line_overrun;
  logic [2:0]  pkt_type;
  int nvec = 0, nerr = 0;
  int cyc = 0, mline = 0, age = 0, rgb_lat = 3, n = 0;
  logic req_prev = 1'b0;
  int log_t[$], log_c[$], ls_c[$], fs_c[$];
  int cmd_ln[8], lpm_ln[8];
  int exp_a[14] = '{0, 5, 1, 5, 1, 2, 3, 4, 1, 2, 3, 4, 1, 5};
  int exp_b[11] = '{0, 1, 1, 2, 3, 4, 1, 2, 3, 4, 1};
  int exp_c[5]  = '{6, 6, 4, 4, 6};
  int exp_l[5]  = '{0, 36, 0, 0, 36};

  dsi_line_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stream_enable (stream_enable),
    .lpm_enable    (lpm_enable),
    .line_period   (line_period),
    .vsa_lines     (vsa_lines),
    .vbp_lines     (vbp_lines),
    .vact_lines    (vact_lines),
    .vfp_lines     (vfp_lines),
    .cmd_pending   (cmd_pending),
    .cmd_min_cycles(cmd_min_cycles),
    .pkt_req       (pkt_req),
    .pkt_type      (pkt_type),
    .pkt_done      (pkt_done),
    .lpm_rqst      (lpm_rqst),
    .frame_start   (frame_start),
    .line_start    (line_start),
    .line_overrun  (line_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic run(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic clear();
    log_t.delete();
    log_c.delete();
    ls_c.delete();
    fs_c.delete();
    for (int i = 0; i < 8; i++) begin
      cmd_ln[i] = 0;
      lpm_ln[i] = 0;
    end
  endtask

  function automatic int logv(input int i);
    return i < log_t.size() ? log_t[i] : -1;
  endfunction

  function automatic int lsv(input int i);
    return i < ls_c.size() ? ls_c[i] : -1000;
  endfunction

  function automatic int sum8(input int a[8]);
    int s = 0;
    for (int i = 0; i < 8; i++) s += a[i];
    return s;
  endfunction

  // assembler model and event recorder, sampled just after each rising edge
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      pkt_done = 1'b0;
      age = 0;
    end else if (pkt_done) pkt_done = 1'b0;
    else if (pkt_req) begin
      age++;
      if (age >= (pkt_type == 3'd3 ? rgb_lat : 3)) begin
        pkt_done = 1'b1;
        age = 0;
      end
    end else age = 0;
    if (frame_start) mline = 0;
    else if (line_start) mline++;
    if (line_start) ls_c.push_back(cyc);
    if (frame_start) fs_c.push_back(cyc);
    if (pkt_req && !req_prev) begin
      log_t.push_back(int'(pkt_type));
      log_c.push_back(cyc);
      if (pkt_type == 3'd6) cmd_ln[mline % 8]++;
    end
    if (lpm_rqst) lpm_ln[mline % 8]++;
    req_prev = pkt_req;
  end

  initial begin
    run(3);
    check("rst_req", pkt_req, 0);
    check("rst_type", pkt_type, 0);
    check("rst_lpm", lpm_rqst, 0);
    check("rst_fs", frame_start, 0);
    check("rst_ls", line_start, 0);
    check("rst_ovr", line_overrun, 0);
    rst_n = 1'b1;
    run(5);
    check("idle_req", pkt_req, 0);
    // blank-fill frames
    clear();
    stream_enable = 1'b1;
    run(420);
    for (int i = 0; i < 28; i++) check($sformatf("seqA%0d", i), logv(i), exp_a[i % 14]);
    check("lineA", lsv(1) - lsv(0), 40);
    check("frameA", (fs_c.size() > 1 ? fs_c[1] - fs_c[0] : 0), 200);
    check("lpmA", sum8(lpm_ln), 0);
    check("ovrA", line_overrun, 0);
    // stop request on line 2 finishes the frame
    for (int i = 0; i < 400 && mline != 2; i++) @(negedge clk);
    check("stop_line", mline, 2);
    stream_enable = 1'b0;
    ls_c.delete();
    fs_c.delete();
    run(200);
    check("stop_ls", ls_c.size(), 2);
    check("stop_fs", fs_c.size(), 0);
    check("stop_req", pkt_req, 0);
    n = log_t.size();
    run(50);
    check("stop_quiet", log_t.size(), n);
    // restart with LPM on non-active lines
    lpm_enable = 1'b1;
    clear();
    stream_enable = 1'b1;
    run(10);
    check("restart_fs", fs_c.size(), 1);
    check("restart_vss", logv(0), 0);
    run(195);
    for (int i = 0; i < 11; i++) check($sformatf("seqB%0d", i), logv(i), exp_b[i]);
    for (int i = 1; i < 5; i++) check($sformatf("lpmB%0d", i), lpm_ln[i], exp_l[i]);
    stream_enable = 1'b0;
    run(250);
    // command slots limited by remaining line time
    lpm_enable = 1'b0;
    cmd_pending = 1'b1;
    cmd_min_cycles = 16'd10;
    clear();
    stream_enable = 1'b1;
    run(5);
    stream_enable = 1'b0;
    run(250);
    for (int i = 0; i < 5; i++) check($sformatf("cmdC%0d", i), cmd_ln[i], exp_c[i]);
    check("cntC", log_t.size(), 40);
    check("ovrC", line_overrun, 0);
    cmd_min_cycles = 16'd40;
    clear();
    stream_enable = 1'b1;
    run(5);
    stream_enable = 1'b0;
    run(250);
    check("cmdC2", sum8(cmd_ln), 0);
    check("cntC2", log_t.size(), 14);
    // slow RGB forces line overrun
    cmd_pending = 1'b0;
    rgb_lat = 60;
    clear();
    stream_enable = 1'b1;
    run(5);
    check("ovr_pre", line_overrun, 0);
    stream_enable = 1'b0;
    run(300);
    check("ovr_set", line_overrun, 1);
    check("ovr_rgb", logv(6), 3);
    check("ovr_hss", logv(7), 1);
    check("ovr_l1", lsv(2) - lsv(1), 40);
    check("ovr_l2", lsv(3) - lsv(2), 69);
    check("ovr_hss_t", (log_c.size() > 7 ? log_c[7] : 0) - lsv(3), 1);
    rgb_lat = 3;
    stream_enable = 1'b1;
    run(2);
    check("ovr_clr", line_overrun, 0);
    // asynchronous reset during RGB
    for (int i = 0; i < 300 && !(pkt_req && pkt_type == 3'd3); i++) @(negedge clk);
    check("rgb_seen", pkt_req && pkt_type == 3'd3, 1);
    #2;
    rst_n = 1'b0;
    stream_enable = 1'b0;
    #1;
    check("arst_req", pkt_req, 0);
    check("arst_type", pkt_type, 0);
    check("arst_lpm", lpm_rqst, 0);
    check("arst_ovr", line_overrun, 0);
    check("arst_ls", line_start, 0);
    check("arst_fs", frame_start, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = log_t.size();
    run(20);
    check("post_idle", log_t.size(), n);
    check("post_req", pkt_req, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
